// File: rtl/pll_cfg_sequencer_if.sv
// Config handshake between system control (master) and the PLL config sequencer (slave).
interface pll_cfg_sequencer_if #(
    parameter int unsigned INT_WIDTH  = 3,
    parameter int unsigned FRAC_WIDTH = 4
) ();
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [INT_WIDTH-1:0]  cfg_int;
    logic [FRAC_WIDTH-1:0] cfg_frac;
    logic                  cfg_err;

    modport master (
        output cfg_valid,
        output cfg_int,
        output cfg_frac,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_int,
        input  cfg_frac,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/pll_cfg_sequencer.sv
// Applies PLL divider configs with a settle window, qualifies lock with bounded retries.
// Optional PLL_SEQ_LOSS_CNT_EN adds a saturating lock-loss counter output.
module pll_cfg_sequencer #(
    parameter int unsigned INT_WIDTH     = 3,
    parameter int unsigned FRAC_WIDTH    = 4,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LOCK_STABLE   = 8,
    parameter int unsigned LOCK_TIMEOUT  = 1024,
    parameter int unsigned MAX_RETRY     = 2
) (
    input  logic                  clk_ref,
    input  logic                  rstn,
    pll_cfg_sequencer_if.slave    cfg,
    input  logic                  lock,
    output logic                  en,
    output logic [INT_WIDTH-1:0]  int_div,
    output logic [FRAC_WIDTH-1:0] frac_div,
    output logic                  pll_ready,
    output logic                  lock_lost,
`ifdef PLL_SEQ_LOSS_CNT_EN
    output logic [7:0]            lock_loss_cnt,
`endif
    output logic                  timeout_err
);

    localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned StabW   = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TmoW    = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned RetryW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
    localparam logic [StabW-1:0]   StabMax    = StabW'(LOCK_STABLE);
    localparam logic [TmoW-1:0]    TmoMax     = TmoW'(LOCK_TIMEOUT);
    localparam logic [RetryW-1:0]  RetryMax   = RetryW'(MAX_RETRY);

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StWaitLock,
        StLocked,
        StFail
    } state_e;

    state_e                state_q, state_d;
    logic                  lock_m_q, lock_s_q;
    logic [SettleW-1:0]    settle_q, settle_d;
    logic [StabW-1:0]      stab_q, stab_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;
    logic [RetryW-1:0]     retry_q, retry_d;
    logic [INT_WIDTH-1:0]  int_q, int_d;
    logic [FRAC_WIDTH-1:0] frac_q, frac_d;
    logic                  lock_lost_q, lock_lost_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  cfg_rdy, take, accept, loss_evt;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        stab_d      = stab_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        int_d       = int_q;
        frac_d      = frac_q;
        lock_lost_d = lock_lost_q;
        cfg_err_d   = 1'b0;
        loss_evt    = 1'b0;

        cfg_rdy = (state_q == StIdle) || (state_q == StLocked) || (state_q == StFail);
        take    = cfg.cfg_valid && cfg_rdy;
        accept  = take && (cfg.cfg_int != '0);

        unique case (state_q)
            StApply: begin
                if (settle_q == SettleLast) begin
                    state_d = StWaitLock;
                    tmo_d   = '0;
                    stab_d  = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StWaitLock: begin
                tmo_d  = tmo_q + 1'b1;
                stab_d = lock_s_q ? stab_q + 1'b1 : '0;
                // Lock qualification takes priority over a coincident timeout.
                if (stab_q == StabMax) begin
                    state_d = StLocked;
                end else if (tmo_q == TmoMax) begin
                    if (retry_q < RetryMax) begin
                        retry_d  = retry_q + 1'b1;
                        settle_d = '0;
                        state_d  = StApply;
                    end else begin
                        state_d = StFail;
                    end
                end
            end
            StLocked: begin
                if (!lock_s_q) begin
                    state_d     = StWaitLock;
                    lock_lost_d = 1'b1;
                    tmo_d       = '0;
                    stab_d      = '0;
                    retry_d     = '0;
                    loss_evt    = 1'b1;
                end
            end
            default: ;
        endcase

        // A new config overrides whatever LOCKED/FAIL would otherwise do this cycle.
        if (accept) begin
            state_d     = StApply;
            settle_d    = '0;
            retry_d     = '0;
            int_d       = cfg.cfg_int;
            frac_d      = cfg.cfg_frac;
            lock_lost_d = 1'b0;
            loss_evt    = 1'b0;
        end else if (take) begin
            cfg_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_ref or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            lock_m_q    <= 1'b0;
            lock_s_q    <= 1'b0;
            settle_q    <= '0;
            stab_q      <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            int_q       <= '0;
            frac_q      <= '0;
            lock_lost_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_m_q    <= lock;
            lock_s_q    <= lock_m_q;
            settle_q    <= settle_d;
            stab_q      <= stab_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            int_q       <= int_d;
            frac_q      <= frac_d;
            lock_lost_q <= lock_lost_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge clk_ref or negedge rstn) begin
        if (!rstn) begin
            loss_cnt_q <= 8'd0;
        end else if (loss_evt && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`else
    logic unused_loss_evt;
    assign unused_loss_evt = loss_evt;
`endif

    assign cfg.cfg_ready = cfg_rdy;
    assign cfg.cfg_err   = cfg_err_q;
    assign en            = (state_q == StWaitLock) || (state_q == StLocked);
    assign pll_ready     = (state_q == StLocked);
    assign timeout_err   = (state_q == StFail);
    assign lock_lost     = lock_lost_q;
    assign int_div       = int_q;
    assign frac_div      = frac_q;

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Directed bench for pll_cfg_sequencer at default parameters.
module tb_pll_cfg_sequencer;

    logic       clk_ref = 1'b0;
    logic       rstn;
    logic       lock;
    logic       en;
    logic [2:0] int_div;
    logic [3:0] frac_div;
    logic       pll_ready;
    logic       lock_lost;
    logic       timeout_err;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int unsigned total = 0;
    int unsigned passed = 0;

    pll_cfg_sequencer_if #(.INT_WIDTH(3), .FRAC_WIDTH(4)) cfg_if ();

    pll_cfg_sequencer dut (
        .clk_ref       (clk_ref),
        .rstn          (rstn),
        .cfg           (cfg_if),
        .lock          (lock),
        .en            (en),
        .int_div       (int_div),
        .frac_div      (frac_div),
        .pll_ready     (pll_ready),
        .lock_lost     (lock_lost),
`ifdef PLL_SEQ_LOSS_CNT_EN
        .lock_loss_cnt (lock_loss_cnt),
`endif
        .timeout_err   (timeout_err)
    );

    always #5 clk_ref = ~clk_ref;

    // Called at a negedge; the offer is taken at the following posedge.
    task automatic apply_cfg(input logic [2:0] i, input logic [3:0] f);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_int   = i;
        cfg_if.cfg_frac  = f;
        @(negedge clk_ref);
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL rst_cfg_ready got %b want 1", cfg_if.cfg_ready); else passed++;
        total++; if (en !== 1'b0) $display("FAIL rst_en got %b want 0", en); else passed++;
        total++; if (pll_ready !== 1'b0) $display("FAIL rst_pll_ready got %b want 0", pll_ready); else passed++;
        total++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout got %b want 0", timeout_err); else passed++;
        total++; if (lock_lost !== 1'b0) $display("FAIL rst_lock_lost got %b want 0", lock_lost); else passed++;
        total++; if (cfg_if.cfg_err !== 1'b0) $display("FAIL rst_cfg_err got %b want 0", cfg_if.cfg_err); else passed++;
        total++; if (int_div !== 3'd0 || frac_div !== 4'd0) $display("FAIL rst_div got %0d/%0d want 0/0", int_div, frac_div); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        int n;
        apply_cfg(3'd4, 4'd4);
        n = 0;
        while (en !== 1'b1 && n < 100) begin n++; @(negedge clk_ref); end
        total++; if (en !== 1'b1) $display("FAIL amid_reach_wait en got %b want 1", en); else passed++;
        @(posedge clk_ref);
        #2 rstn = 1'b0;
        #1;
        total++; if (en !== 1'b0) $display("FAIL amid_en got %b want 0", en); else passed++;
        total++; if (pll_ready !== 1'b0) $display("FAIL amid_pll_ready got %b want 0", pll_ready); else passed++;
        total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL amid_cfg_ready got %b want 1", cfg_if.cfg_ready); else passed++;
        total++; if (int_div !== 3'd0) $display("FAIL amid_int_div got %0d want 0", int_div); else passed++;
        @(negedge clk_ref);
        rstn = 1'b1;
        @(negedge clk_ref);
    endtask

    task automatic test_lock();
        int n, k;
        lock = 1'b0;
        apply_cfg(3'd3, 4'd5);
        total++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL lk_ready_apply got %b want 0", cfg_if.cfg_ready); else passed++;
        n = 0;
        while (en === 1'b0 && n < 100) begin n++; @(negedge clk_ref); end
        total++; if (n != 16) $display("FAIL lk_settle_len got %0d want 16", n); else passed++;
        total++; if (int_div !== 3'd3 || frac_div !== 4'd5) $display("FAIL lk_div got %0d/%0d want 3/5", int_div, frac_div); else passed++;
        repeat (30) @(negedge clk_ref);
        lock = 1'b1;
        k = 0;
        while (pll_ready !== 1'b1 && k < 100) begin k++; @(negedge clk_ref); end
        total++; if (k + 30 < 39 || k + 30 > 41) $display("FAIL lk_latency got %0d want 39..41", k + 30); else passed++;
        total++; if (en !== 1'b1 || lock_lost !== 1'b0) $display("FAIL lk_state en=%b lost=%b want 1/0", en, lock_lost); else passed++;
        total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL lk_ready_locked got %b want 1", cfg_if.cfg_ready); else passed++;
    endtask

    task automatic test_cfg_err();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_int   = 3'd0;
        cfg_if.cfg_frac  = 4'd9;
        @(negedge clk_ref);
        cfg_if.cfg_valid = 1'b0;
        total++; if (cfg_if.cfg_err !== 1'b1) $display("FAIL err_pulse got %b want 1", cfg_if.cfg_err); else passed++;
        total++; if (en !== 1'b1 || pll_ready !== 1'b1) $display("FAIL err_state en=%b rdy=%b want 1/1", en, pll_ready); else passed++;
        total++; if (int_div !== 3'd3 || frac_div !== 4'd5) $display("FAIL err_div got %0d/%0d want 3/5", int_div, frac_div); else passed++;
        @(negedge clk_ref);
        total++; if (cfg_if.cfg_err !== 1'b0) $display("FAIL err_one_cycle got %b want 0", cfg_if.cfg_err); else passed++;
    endtask

    task automatic test_lock_loss();
        int k;
        lock = 1'b0;
        repeat (3) @(negedge clk_ref);
        total++; if (pll_ready !== 1'b0) $display("FAIL loss_pll_ready got %b want 0", pll_ready); else passed++;
        total++; if (lock_lost !== 1'b1) $display("FAIL loss_flag got %b want 1", lock_lost); else passed++;
        total++; if (en !== 1'b1) $display("FAIL loss_en got %b want 1", en); else passed++;
        lock = 1'b1;
        k = 0;
        while (pll_ready !== 1'b1 && k < 50) begin k++; @(negedge clk_ref); end
        total++; if (pll_ready !== 1'b1) $display("FAIL relock_ready got %b want 1", pll_ready); else passed++;
        total++; if (lock_lost !== 1'b1) $display("FAIL relock_sticky got %b want 1", lock_lost); else passed++;
`ifdef PLL_SEQ_LOSS_CNT_EN
        total++; if (lock_loss_cnt !== 8'd1) $display("FAIL loss_cnt got %0d want 1", lock_loss_cnt); else passed++;
`endif
    endtask

    task automatic test_new_cfg();
        int k;
        apply_cfg(3'd5, 4'd2);
        total++; if (en !== 1'b0) $display("FAIL new_en got %b want 0", en); else passed++;
        total++; if (int_div !== 3'd5 || frac_div !== 4'd2) $display("FAIL new_div got %0d/%0d want 5/2", int_div, frac_div); else passed++;
        total++; if (lock_lost !== 1'b0) $display("FAIL new_lost_clr got %b want 0", lock_lost); else passed++;
        // Offer during APPLY must be ignored, without an error pulse.
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_int   = 3'd7;
        cfg_if.cfg_frac  = 4'd1;
        repeat (2) @(negedge clk_ref);
        cfg_if.cfg_valid = 1'b0;
        total++; if (int_div !== 3'd5 || cfg_if.cfg_err !== 1'b0) $display("FAIL busy_ignore div=%0d err=%b want 5/0", int_div, cfg_if.cfg_err); else passed++;
        k = 0;
        while (pll_ready !== 1'b1 && k < 100) begin k++; @(negedge clk_ref); end
        total++; if (pll_ready !== 1'b1) $display("FAIL new_relock got %b want 1", pll_ready); else passed++;
    endtask

    task automatic test_timeout();
        int n, windows;
        logic prev_en;
        lock = 1'b0;
        apply_cfg(3'd2, 4'd1);
        prev_en = 1'b1;
        windows = 0;
        n = 0;
        while (timeout_err !== 1'b1 && n < 4000) begin
            if (!en && prev_en) windows++;
            prev_en = en;
            n++;
            @(negedge clk_ref);
        end
        total++; if (timeout_err !== 1'b1) $display("FAIL tmo_reached got %b want 1", timeout_err); else passed++;
        total++; if (windows != 3) $display("FAIL tmo_windows got %0d want 3", windows); else passed++;
        total++; if (n < 3120 || n > 3126) $display("FAIL tmo_cycles got %0d want 3120..3126", n); else passed++;
        total++; if (en !== 1'b0 || pll_ready !== 1'b0) $display("FAIL tmo_outputs en=%b rdy=%b want 0/0", en, pll_ready); else passed++;
        total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL tmo_cfg_ready got %b want 1", cfg_if.cfg_ready); else passed++;
        repeat (5) @(negedge clk_ref);
        total++; if (timeout_err !== 1'b1) $display("FAIL tmo_sticky got %b want 1", timeout_err); else passed++;
    endtask

    task automatic test_recover();
        lock = 1'b1;
        apply_cfg(3'd1, 4'd0);
        total++; if (timeout_err !== 1'b0) $display("FAIL rec_tmo_clr got %b want 0", timeout_err); else passed++;
        total++; if (int_div !== 3'd1 || en !== 1'b0) $display("FAIL rec_apply div=%0d en=%b want 1/0", int_div, en); else passed++;
    endtask

    initial begin
        rstn             = 1'b0;
        lock             = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_int   = 3'd0;
        cfg_if.cfg_frac  = 4'd0;
        #1;
        test_reset();
        repeat (2) @(negedge clk_ref);
        rstn = 1'b1;
        @(negedge clk_ref);
        test_reset_mid_wait();
        test_lock();
        test_cfg_err();
        test_lock_loss();
        test_new_cfg();
        test_timeout();
        test_recover();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
